fnd_counter_ctrl: RTL and testbench
===================================

// Module: fnd_counter_ctrl
// PURPOSE
//  Parametrised successor of the 4-digit 0..9999 counter/display top. One clock domain: an internal
//  prescaler produces a one-cycle count-enable (no derived clocks); an up/down counter with run, clear
//  and load; and a multiplexed common-anode 7-segment driver for DIGITS digits, with optional
//  leading-zero blanking and a run-indicator decimal point.
// PARAMETERS
//  CLK_FREQ   100_000_000  input clock frequency, Hz
//  TICK_HZ    1            count rate, Hz; TICK_DIV = CLK_FREQ/TICK_HZ (must divide exactly, >=2)
//  SCAN_HZ    1000         full-display refresh, Hz; SCAN_DIV = CLK_FREQ/(SCAN_HZ*DIGITS) (exact, >=2)
//  DIGITS     4            number of displayed digits, 1..8
//  MAX_COUNT  9999         terminal count; must be <= 10**DIGITS-1; CNT_W = $clog2(MAX_COUNT+1)
//  BLANK_LZ   0            1 = blank leading zero digits (digit 0 is never blanked)
//  DP_DIGIT   0            digit index whose decimal point shows the run flag
// PORTS
//  clk       in   1          system clock
//  rst       in   1          asynchronous, active-low reset
//  run       in   1          1 = counting enabled, 0 = paused (prescaler holds)
//  clear     in   1          synchronous clear of count and prescaler
//  up_down   in   1          1 = count up, 0 = count down
//  load      in   1          synchronous load of load_val
//  load_val  in   CNT_W      value to load
//  cnt       out  CNT_W      current count, binary
//  wrap      out  1          one-cycle pulse on wrap-around
//  fnd_data  out  8          segments {dp,g,f,e,d,c,b,a}, active-low
//  fnd_com   out  DIGITS     digit commons, active-low one-hot
// BEHAVIOUR
//  Reset (rst=0, async): cnt=0, prescaler=0, scan_cnt=0, sel=0, wrap=0, fnd_data=8'hFF,
//   fnd_com=all ones (display dark). Reset mid-operation aborts everything immediately.
//  Prescaler: presc counts 0..TICK_DIV-1 while run=1; tick=1 for exactly the cycle presc==TICK_DIV-1
//   and run=1, presc then returns to 0. run=0 freezes presc (resume completes the partial period).
//  Counter priority per cycle: clear > load > tick.
//   clear: cnt<=0, presc<=0, wrap<=0 (regardless of run).
//   load: cnt<=min(load_val,MAX_COUNT); presc unaffected; a coincident tick is discarded.
//   tick & up_down=1: cnt==MAX_COUNT ? 0 : cnt+1.  tick & up_down=0: cnt==0 ? MAX_COUNT : cnt-1.
//   wrap registered: 1 in the cycle after a tick that wrapped (same edge cnt changes), else 0.
//   up_down may change at any time; takes effect on the next tick.
//  Scan: scan_cnt counts 0..SCAN_DIV-1 free-running (independent of run/clear);
//   at SCAN_DIV-1, sel <= (sel==DIGITS-1) ? 0 : sel+1. Digit k value = (cnt / 10**k) % 10.
//  Display outputs registered, one cycle after sel/cnt: fnd_com[sel]=0, all other bits 1.
//   Segment codes 0..9 (bits g..a): 40,79,24,30,19,12,02,78,00,10 (hex, 7-bit).
//   dp (bit7) = 0 only when sel==DP_DIGIT and run=1, else 1.
//   BLANK_LZ=1: digit k>0 with 10**k > cnt shows 8'hFF except dp rule still applies.
//  No divide-by-clock: every register on clk; outputs glitch-free (all registered).
// TESTING (sim params CLK_FREQ=100, TICK_HZ=10 -> TICK_DIV=10, SCAN_HZ=5, DIGITS=4 -> SCAN_DIV=5,
//   MAX_COUNT=9999 unless stated)
//  1 Reset then run=1,up_down=1 for 35 cycles -> cnt=3; ticks at cycles 10,20,30; fnd_com walks
//    1110,1101,1011,0111 every 5 cycles; digit0 fnd_data=8'h79 (dp=0 -> bit7 0) when cnt=1.
//  2 load=1 load_val=9998, up -> after 2 ticks cnt=0 with wrap=1 for exactly one cycle; down from 0
//    -> cnt=9999, wrap pulse; load_val=12000 -> cnt=9999 (clamped).
//  3 run=0 at presc=6 for 50 cycles, then run=1 -> next tick 3 cycles later; cnt unchanged while paused;
//    dp on DP_DIGIT goes to 1 while paused.
//  4 clear and load and tick in same cycle -> cnt=0, presc=0, wrap=0; load+tick -> cnt=load_val only.
//  5 BLANK_LZ=1, cnt=7 -> digits 3..1 show 8'hFF, digit0 shows 8'h78|dp; cnt=0 -> digit0 shows '0'.
//  6 rst pulsed low mid-scan at sel=2, cnt=42 -> outputs immediately 8'hFF/all-ones, cnt=0, sel=0.

Source files
------------

// File: rtl/fnd_counter_ctrl.sv
// Up/down 0..MAX_COUNT counter with internal prescaler and multiplexed common-anode 7-segment driver.
// Latency: cnt/wrap update on the tick edge; fnd_data/fnd_com are registered one cycle after sel/cnt.
// Backpressure: none; free-running display scan, counting gated only by run/clear/load.
module fnd_counter_ctrl #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 1,
    parameter int SCAN_HZ   = 1000,
    parameter int DIGITS    = 4,
    parameter int MAX_COUNT = 9999,
    parameter int BLANK_LZ  = 0,
    parameter int DP_DIGIT  = 0,
    localparam int CNT_W    = $clog2(MAX_COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              clear,
    input  logic              up_down,
    input  logic              load,
    input  logic [CNT_W-1:0]  load_val,
    output logic [CNT_W-1:0]  cnt,
    output logic              wrap,
    output logic [7:0]        fnd_data,
    output logic [DIGITS-1:0] fnd_com
);
    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int SCAN_DIV = CLK_FREQ / (SCAN_HZ * DIGITS);
    localparam int PRESC_W  = $clog2(TICK_DIV);
    localparam int SCAN_W   = $clog2(SCAN_DIV);
    localparam int SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic int unsigned pow10(input int k);
        int unsigned p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [SEL_W-1:0]   sel;

    // Paused prescaler holds its phase so a resume completes the partial period.
    assign tick = run && (presc == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (run) begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            cnt  <= (load_val > CNT_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : load_val;
            wrap <= 1'b0;
        end else if (tick) begin
            if (up_down) begin
                cnt  <= (cnt == CNT_W'(MAX_COUNT)) ? '0 : cnt + CNT_W'(1);
                wrap <= (cnt == CNT_W'(MAX_COUNT));
            end else begin
                cnt  <= (cnt == '0) ? CNT_W'(MAX_COUNT) : cnt - CNT_W'(1);
                wrap <= (cnt == '0);
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            sel      <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            sel      <= (sel == SEL_W'(DIGITS - 1)) ? '0 : sel + SEL_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    logic [3:0]        dig [DIGITS];
    logic [DIGITS-1:0] lead_blank;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        localparam int unsigned P = pow10(k);
        assign dig[k] = 4'((32'(cnt) / P) % 32'd10);
        if (k == 0 || BLANK_LZ == 0) begin : g_keep
            assign lead_blank[k] = 1'b0;
        end else begin : g_blank
            assign lead_blank[k] = (32'(cnt) < P);
        end
    end

    logic [DIGITS-1:0] com_nxt;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;

    always_comb begin
        com_nxt      = '1;
        com_nxt[sel] = 1'b0;
        seg_nxt      = lead_blank[sel] ? 7'h7F : seg7(dig[sel]);
        dp_nxt       = !(run && (sel == SEL_W'(DP_DIGIT)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fnd_data <= 8'hFF;
            fnd_com  <= '1;
        end else begin
            fnd_data <= {dp_nxt, seg_nxt};
            fnd_com  <= com_nxt;
        end
    end
endmodule

// File: tb/tb_fnd_counter_ctrl.sv
// Bench for fnd_counter_ctrl: vector table, hand sequences for blanking and mid-scan reset, random run
// against an arithmetic reference model. Two instances: A plain, B with leading-zero blanking and dp on digit 2.
module tb_fnd_counter_ctrl;
    localparam int TDIV = 10;
    localparam int SDIV = 5;
    localparam int MAXC = 9999;
    localparam logic [6:0] SEGTAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic        clk;
    logic        rst;
    logic        run, clear, up_down, load;
    logic [13:0] load_val;
    logic [13:0] cnt_a, cnt_b;
    logic        wrap_a, wrap_b;
    logic [7:0]  data_a, data_b;
    logic [3:0]  com_a, com_b;

    fnd_counter_ctrl #(.CLK_FREQ(100), .TICK_HZ(10), .SCAN_HZ(5), .DIGITS(4), .MAX_COUNT(MAXC),
                       .BLANK_LZ(0), .DP_DIGIT(0)) dut_a (
        .clk(clk), .rst(rst), .run(run), .clear(clear), .up_down(up_down), .load(load),
        .load_val(load_val), .cnt(cnt_a), .wrap(wrap_a), .fnd_data(data_a), .fnd_com(com_a));

    fnd_counter_ctrl #(.CLK_FREQ(100), .TICK_HZ(10), .SCAN_HZ(5), .DIGITS(4), .MAX_COUNT(MAXC),
                       .BLANK_LZ(1), .DP_DIGIT(2)) dut_b (
        .clk(clk), .rst(rst), .run(run), .clear(clear), .up_down(up_down), .load(load),
        .load_val(load_val), .cnt(cnt_b), .wrap(wrap_b), .fnd_data(data_b), .fnd_com(com_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counter value, prescaler phase and scan position as plain integers.
    int         m_presc, m_cnt, m_wrap, m_scan, m_sel;
    logic [7:0] m_data_a, m_data_b;
    logic [3:0] m_com;

    function automatic logic [7:0] disp(int c, int k, bit blank, int dpd, bit r);
        int p;
        logic [6:0] s;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        s = SEGTAB[(c / p) % 10];
        if (blank && k > 0 && c < p) s = 7'h7F;
        return {(k == dpd && r) ? 1'b0 : 1'b1, s};
    endfunction

    task automatic model_reset();
        m_presc = 0; m_cnt = 0; m_wrap = 0; m_scan = 0; m_sel = 0;
        m_data_a = 8'hFF; m_data_b = 8'hFF; m_com = 4'hF;
    endtask

    task automatic model_clock();
        bit t;
        t = run && (m_presc == TDIV - 1);
        m_com = 4'hF;
        m_com[m_sel] = 1'b0;
        m_data_a = disp(m_cnt, m_sel, 1'b0, 0, run);
        m_data_b = disp(m_cnt, m_sel, 1'b1, 2, run);
        if (clear) begin
            m_cnt = 0; m_wrap = 0; m_presc = 0;
        end else begin
            if (run) m_presc = t ? 0 : m_presc + 1;
            m_wrap = 0;
            if (load) begin
                m_cnt = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
            end else if (t) begin
                if (up_down) begin
                    m_wrap = (m_cnt == MAXC);
                    m_cnt  = (m_cnt + 1) % (MAXC + 1);
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt == 0) ? MAXC : m_cnt - 1;
                end
            end
        end
        if (m_scan == SDIV - 1) begin
            m_scan = 0;
            m_sel  = (m_sel + 1) % 4;
        end else begin
            m_scan++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        #1;
        check("cnt_a", 32'(cnt_a), m_cnt);
        check("wrap_a", 32'(wrap_a), m_wrap);
        check("data_a", 32'(data_a), 32'(m_data_a));
        check("com_a", 32'(com_a), 32'(m_com));
        check("data_b", 32'(data_b), 32'(m_data_b));
        check("cnt_b", 32'(cnt_b), m_cnt);
    endtask

    task automatic wait_com_b(input logic [3:0] want);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (com_b == want) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_com: got %b expected %b within 30 cycles", com_b, want);
        end
    endtask

    typedef struct {
        bit run, clr, ud, ld;
        int lv;
        int ncyc;
        int exp_cnt;
        bit exp_wrap;
    } vec_t;

    vec_t tbl [21];

    initial begin
        tbl[0]  = '{1, 0, 1, 0, 0,     35, 3,    0};
        tbl[1]  = '{0, 0, 1, 1, 9998,  1,  9998, 0};
        tbl[2]  = '{1, 0, 1, 0, 0,     5,  9999, 0};
        tbl[3]  = '{1, 0, 1, 0, 0,     10, 0,    1};
        tbl[4]  = '{1, 0, 1, 0, 0,     1,  0,    0};
        tbl[5]  = '{1, 0, 0, 0, 0,     9,  9999, 1};
        tbl[6]  = '{0, 0, 0, 1, 12000, 1,  9999, 0};
        tbl[7]  = '{0, 0, 1, 1, 42,    1,  42,   0};
        tbl[8]  = '{1, 0, 1, 0, 0,     9,  42,   0};
        tbl[9]  = '{1, 1, 1, 1, 500,   1,  0,    0};
        tbl[10] = '{1, 0, 1, 0, 0,     5,  0,    0};
        tbl[11] = '{0, 1, 1, 0, 0,     1,  0,    0};
        tbl[12] = '{1, 0, 1, 0, 0,     9,  0,    0};
        tbl[13] = '{1, 0, 1, 0, 0,     1,  1,    0};
        tbl[14] = '{1, 0, 1, 0, 0,     9,  1,    0};
        tbl[15] = '{1, 0, 1, 1, 77,    1,  77,   0};
        tbl[16] = '{1, 0, 1, 0, 0,     10, 78,   0};
        tbl[17] = '{1, 0, 1, 0, 0,     6,  78,   0};
        tbl[18] = '{0, 0, 1, 0, 0,     50, 78,   0};
        tbl[19] = '{1, 0, 1, 0, 0,     3,  78,   0};
        tbl[20] = '{1, 0, 1, 0, 0,     1,  79,   0};

        rst = 1'b0; run = 1'b0; clear = 1'b0; up_down = 1'b1; load = 1'b0; load_val = '0;
        model_reset();
        #12;
        check("rst_cnt", 32'(cnt_a), 0);
        check("rst_wrap", 32'(wrap_a), 0);
        check("rst_data", 32'(data_a), 32'h0FF);
        check("rst_com", 32'(com_a), 32'hF);
        rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            run = tbl[i].run; clear = tbl[i].clr; up_down = tbl[i].ud;
            load = tbl[i].ld; load_val = 14'(tbl[i].lv);
            repeat (tbl[i].ncyc) cycle();
            check($sformatf("tbl%0d_cnt", i), 32'(cnt_a), tbl[i].exp_cnt);
            check($sformatf("tbl%0d_wrap", i), 32'(wrap_a), 32'(tbl[i].exp_wrap));
        end

        // Leading-zero blanking on B with the counter paused at 7, then at 0.
        run = 1'b0; clear = 1'b0; load = 1'b1; load_val = 14'd7;
        cycle();
        load = 1'b0;
        wait_com_b(4'b1110);
        check("blank_d0_7", 32'(data_b), 32'hF8);
        wait_com_b(4'b0111);
        check("blank_d3_7", 32'(data_b), 32'hFF);
        wait_com_b(4'b1011);
        check("blank_d2_7", 32'(data_b), 32'hFF);
        load = 1'b1; load_val = 14'd0;
        cycle();
        load = 1'b0;
        wait_com_b(4'b1110);
        check("blank_d0_0", 32'(data_b), 32'hC0);

        // Reset in the middle of a scan while digit 2 is lit.
        load = 1'b1; load_val = 14'd42;
        cycle();
        load = 1'b0; run = 1'b1;
        wait_com_b(4'b1011);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(cnt_a), 0);
        check("mid_rst_data", 32'(data_a), 32'h0FF);
        check("mid_rst_com", 32'(com_a), 32'hF);
        model_reset();
        #2 rst = 1'b1;
        cycle();
        check("mid_rst_sel0", 32'(com_a), 32'hE);

        // Random traffic against the model.
        up_down = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            clear = ($urandom_range(99) == 0);
            load  = ($urandom_range(39) == 0);
            run   = ($urandom_range(7) != 0);
            if ($urandom_range(49) == 0) up_down = ~up_down;
            sel = $urandom_range(3);
            if (sel == 0)      load_val = 14'(9990 + $urandom_range(19));
            else if (sel == 1) load_val = 14'($urandom_range(19));
            else               load_val = 14'($urandom_range(16383));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
